// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: NUM_CH hobby-servo PWM channels sharing one frame timebase.
// Each channel either tracks a clamped target width or sweeps MIN_US..MAX_US,
// moving at most STEP_US per update tick. A channel's width is latched at frame
// start, so a pulse already in progress never changes length.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake (ready drops only on the update-tick cycle)
//   cmd_chan          target channel
//   cmd_mode          0 = track cmd_width_us, 1 = sweep
//   cmd_width_us      target width in us (clamped to MIN_US..MAX_US)
//   cmd_err           one-cycle pulse after accepting a command for a missing channel
//   mon_chan          channel shown on mon_width_us (0 when out of range)
//   frame_start       one-cycle pulse at the start of every frame
//   at_target         per channel: tracking and ramped width equals target
//   pwm_out           servo pulse outputs
module servo_pwm_bank #(
    parameter int unsigned NUM_CH     = 5,
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned FRAME_US   = 20000,
    parameter int unsigned MIN_US     = 1000,
    parameter int unsigned MAX_US     = 2000,
    parameter int unsigned STEP_US    = 10,
    parameter int unsigned UPDATE_DIV = 250000,
    localparam int unsigned CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CW-1:0]     cmd_chan,
    input  logic              cmd_mode,
    input  logic [15:0]       cmd_width_us,
    output logic              cmd_err,
    input  logic [CW-1:0]     mon_chan,
    output logic [15:0]       mon_width_us,
    output logic              frame_start,
    output logic [NUM_CH-1:0] at_target,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam int unsigned PSC_DIV = CLK_HZ / 1_000_000;
    localparam int unsigned PSC_W   = (PSC_DIV > 1) ? $clog2(PSC_DIV) : 1;
    localparam int unsigned UPD_W   = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;

    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PSC_DIV - 1);
    localparam logic [15:0]      FUS_LAST = 16'(FRAME_US - 1);
    localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(UPDATE_DIV - 1);
    localparam logic [15:0]      MIN_W    = 16'(MIN_US);
    localparam logic [15:0]      MAX_W    = 16'(MAX_US);
    localparam logic [15:0]      MID_W    = 16'((MIN_US + MAX_US) / 2);
    localparam logic [16:0]      STEP_W   = 17'(STEP_US);
    localparam logic [CW:0]      NCH_W    = (CW + 1)'(NUM_CH);

    logic [PSC_W-1:0] psc;
    logic [15:0]      frame_us;
    logic [15:0]      fus_q;       // frame_us delayed to line up with frame_start
    logic [UPD_W-1:0] upd_cnt;
    logic             tick_q;
    logic             primed;      // suppresses pwm until the first frame_start

    logic [15:0]       target [NUM_CH];
    logic [15:0]       cur    [NUM_CH];
    logic [15:0]       active [NUM_CH];
    logic [NUM_CH-1:0] mode;
    logic [NUM_CH-1:0] dir;

    logic              psc_wrap_c;
    logic              frame_zero_c;
    logic [UPD_W-1:0]  upd_nxt_c;
    logic              accept_c;
    logic              chan_ok_c;
    logic [15:0]       clamp_c;
    logic [15:0]       cur_nxt_c [NUM_CH];
    logic [NUM_CH-1:0] dir_nxt_c;

    // Move c toward t by at most STEP_US, never overshooting; 17-bit so no wrap.
    function automatic logic [15:0] step_toward(input logic [15:0] c, input logic [15:0] t);
        logic [16:0] c17;
        logic [16:0] t17;
        logic [16:0] r;
        c17 = {1'b0, c};
        t17 = {1'b0, t};
        if (c17 < t17)
            r = (c17 + STEP_W > t17) ? t17 : c17 + STEP_W;
        else if (c17 > t17)
            r = (c17 < t17 + STEP_W) ? t17 : c17 - STEP_W;
        else
            r = c17;
        return r[15:0];
    endfunction

    // Counter decode and command qualification.
    always_comb begin
        psc_wrap_c   = (psc == PSC_LAST);
        frame_zero_c = (psc == '0) && (frame_us == '0);
        upd_nxt_c    = (upd_cnt == UPD_LAST) ? '0 : upd_cnt + UPD_W'(1);
        accept_c     = cmd_valid && cmd_ready;
        chan_ok_c    = ({1'b0, cmd_chan} < NCH_W);
        clamp_c      = (cmd_width_us < MIN_W) ? MIN_W :
                       (cmd_width_us > MAX_W) ? MAX_W : cmd_width_us;
    end

    // Per-channel width/direction applied on the next update tick.
    always_comb begin
        cur_nxt_c = cur;
        dir_nxt_c = dir;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!mode[i]) begin
                cur_nxt_c[i] = step_toward(cur[i], target[i]);
            end else if (dir[i]) begin
                if (cur[i] >= MAX_W) dir_nxt_c[i] = 1'b0;
                else                 cur_nxt_c[i] = step_toward(cur[i], MAX_W);
            end else begin
                if (cur[i] <= MIN_W) dir_nxt_c[i] = 1'b1;
                else                 cur_nxt_c[i] = step_toward(cur[i], MIN_W);
            end
        end
    end

    // Timebase: us prescaler, frame position and update-tick divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc         <= '0;
            frame_us    <= '0;
            fus_q       <= '0;
            upd_cnt     <= '0;
            tick_q      <= 1'b0;
            cmd_ready   <= 1'b1;
            frame_start <= 1'b0;
            primed      <= 1'b0;
        end else begin
            psc <= psc_wrap_c ? '0 : psc + PSC_W'(1);
            if (psc_wrap_c)
                frame_us <= (frame_us == FUS_LAST) ? '0 : frame_us + 16'(1);
            fus_q       <= frame_us;
            upd_cnt     <= upd_nxt_c;
            tick_q      <= (upd_nxt_c == UPD_LAST);
            cmd_ready   <= (upd_nxt_c != UPD_LAST);
            frame_start <= frame_zero_c;
            primed      <= primed || frame_start;
        end
    end

    // Channel state: commands, ramp updates and frame-start width capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                target[i] <= MID_W;
                cur[i]    <= MID_W;
                active[i] <= MID_W;
            end
            mode    <= '0;
            dir     <= '1;
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= accept_c && !chan_ok_c;
            if (tick_q) begin
                cur <= cur_nxt_c;
                dir <= dir_nxt_c;
            end
            if (accept_c && chan_ok_c) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (cmd_chan == CW'(i)) begin
                        mode[i] <= cmd_mode;
                        if (!cmd_mode) target[i] <= clamp_c;
                    end
                end
            end
            // Same-edge capture sees cur from before any coincident tick.
            if (frame_zero_c) active <= cur;
        end
    end

    // Outputs registered from channel state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out      <= '0;
            at_target    <= '1;
            mon_width_us <= '0;
        end else begin
            mon_width_us <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i]   <= (primed || frame_start) && (fus_q < active[i]);
                at_target[i] <= !mode[i] && (cur[i] == target[i]);
                if (mon_chan == CW'(i)) mon_width_us <= cur[i];
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Self-checking bench for servo_pwm_bank with a scaled-down timebase
// (2 clocks per us, 250 us frame, 100..200 us range, 3 us steps, tick every 37 clocks).
module tb_servo_pwm_bank;

    localparam int NCH      = 5;
    localparam int CLK_HZ   = 2_000_000;
    localparam int FRAME_US = 250;
    localparam int MIN_US   = 100;
    localparam int MAX_US   = 200;
    localparam int STEP_US  = 3;
    localparam int UDIV     = 37;
    localparam int PER      = CLK_HZ / 1_000_000;
    localparam int F        = FRAME_US * PER;
    localparam int MID      = (MIN_US + MAX_US) / 2;
    localparam int CW       = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [CW-1:0]   cmd_chan = '0;
    logic            cmd_mode = 1'b0;
    logic [15:0]     cmd_width_us = '0;
    logic            cmd_err;
    logic [CW-1:0]   mon_chan = '0;
    logic [15:0]     mon_width_us;
    logic            frame_start;
    logic [NCH-1:0]  at_target;
    logic [NCH-1:0]  pwm_out;

    servo_pwm_bank #(
        .NUM_CH(NCH), .CLK_HZ(CLK_HZ), .FRAME_US(FRAME_US), .MIN_US(MIN_US),
        .MAX_US(MAX_US), .STEP_US(STEP_US), .UPDATE_DIV(UDIV)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_chan(cmd_chan), .cmd_mode(cmd_mode), .cmd_width_us(cmd_width_us),
        .cmd_err(cmd_err), .mon_chan(mon_chan), .mon_width_us(mon_width_us),
        .frame_start(frame_start), .at_target(at_target), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    // Behavioural model: channel state, plus the cycle index k since reset release.
    int m_cur [NCH];
    int m_tgt [NCH];
    int m_act [NCH];
    bit m_mode[NCH];
    bit m_dir [NCH];
    int k;
    int n_ticks;
    int errors;
    int checks;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s k=%0d got=%0d want=%0d", name, k, got, want);
        end
    endtask

    function automatic int clamp(input int w);
        return (w < MIN_US) ? MIN_US : (w > MAX_US) ? MAX_US : w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cur[i] = MID; m_tgt[i] = MID; m_act[i] = MID;
            m_mode[i] = 1'b0; m_dir[i] = 1'b1;
        end
        k = 0;
    endtask

    task automatic model_step(input int i);
        if (!m_mode[i]) begin
            if (m_cur[i] < m_tgt[i])
                m_cur[i] = (m_cur[i] + STEP_US > m_tgt[i]) ? m_tgt[i] : m_cur[i] + STEP_US;
            else if (m_cur[i] > m_tgt[i])
                m_cur[i] = (m_cur[i] - STEP_US < m_tgt[i]) ? m_tgt[i] : m_cur[i] - STEP_US;
        end else if (m_dir[i]) begin
            if (m_cur[i] >= MAX_US) m_dir[i] = 1'b0;
            else m_cur[i] = (m_cur[i] + STEP_US > MAX_US) ? MAX_US : m_cur[i] + STEP_US;
        end else begin
            if (m_cur[i] <= MIN_US) m_dir[i] = 1'b1;
            else m_cur[i] = (m_cur[i] - STEP_US < MIN_US) ? MIN_US : m_cur[i] - STEP_US;
        end
    endtask

    // Advance one clock: predict the edge in the model, then compare every output.
    task automatic cycle();
        int pc[NCH];
        int pt[NCH];
        bit pm[NCH];
        bit acc, tk, bad;
        int mc, ch, r;
        logic [NCH-1:0] exp_pwm, exp_at;
        pc = m_cur; pt = m_tgt; pm = m_mode;
        mc  = int'(mon_chan);
        ch  = int'(cmd_chan);
        tk  = (k % UDIV == UDIV - 1);
        acc = cmd_valid && !tk;
        bad = acc && (ch >= NCH);
        if (k % F == 0)
            for (int i = 0; i < NCH; i++) m_act[i] = m_cur[i];
        if (tk) begin
            n_ticks++;
            for (int i = 0; i < NCH; i++) model_step(i);
        end
        if (acc && !bad) begin
            m_mode[ch] = cmd_mode;
            if (!cmd_mode) m_tgt[ch] = clamp(int'(cmd_width_us));
        end
        @(posedge clk);
        k++;
        #1;
        r = k % F;
        for (int i = 0; i < NCH; i++) begin
            exp_pwm[i] = (r >= 2) && (r <= PER * m_act[i] + 1);
            exp_at[i]  = !pm[i] && (pc[i] == pt[i]);
        end
        chk("frame_start", 32'(frame_start), 32'(r == 1));
        chk("cmd_ready", 32'(cmd_ready), 32'(k % UDIV != UDIV - 1));
        chk("cmd_err", 32'(cmd_err), 32'(bad));
        chk("pwm_out", 32'(pwm_out), 32'(exp_pwm));
        chk("at_target", 32'(at_target), 32'(exp_at));
        chk("mon_width", 32'(mon_width_us), (mc < NCH) ? 32'(pc[mc]) : 32'd0);
    endtask

    task automatic send_cmd(input int chan, input bit mode, input int width, output int ncyc);
        bit ok;
        cmd_chan = CW'(chan); cmd_mode = mode; cmd_width_us = 16'(width);
        cmd_valid = 1'b1;
        ncyc = 0;
        ok = 1'b0;
        while (!ok && ncyc < 3) begin
            ok = (k % UDIV != UDIV - 1);
            cycle();
            ncyc++;
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", 32'(ok), 32'd1);
    endtask

    // Run until n more update ticks have happened, then one cycle for output latency.
    task automatic wait_ticks(input int n);
        int tgt;
        tgt = n_ticks + n;
        while (n_ticks < tgt) cycle();
        cycle();
    endtask

    task automatic do_reset();
        #3 rst = 1'b1;
        #2;
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        chk("rst_at_target", 32'(at_target), 32'h1f);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        int chan;
        bit mode;
        int width;
        int exp_w;
    } vec_t;

    vec_t tbl[5];
    int   hi[NCH];
    int   n, errs;

    initial begin
        errors = 0; checks = 0; n_ticks = 0;
        tbl[0] = '{chan: 2, mode: 1'b0, width: 200, exp_w: 200};
        tbl[1] = '{chan: 0, mode: 1'b0, width: 50,  exp_w: 100};
        tbl[2] = '{chan: 0, mode: 1'b0, width: 300, exp_w: 200};
        tbl[3] = '{chan: 1, mode: 1'b0, width: 123, exp_w: 123};
        tbl[4] = '{chan: 3, mode: 1'b0, width: 0,   exp_w: 100};

        model_reset();
        #1;
        do_reset();

        // First frame after reset: every channel high for 150 us = 300 clocks.
        for (int i = 0; i < NCH; i++) hi[i] = 0;
        for (int j = 0; j < F; j++) begin
            cycle();
            for (int i = 0; i < NCH; i++) hi[i] += int'(pwm_out[i]);
        end
        for (int i = 0; i < NCH; i++) chk("first_frame_high", 32'(hi[i]), 32'd300);

        // Track commands including clamping at both ends.
        foreach (tbl[t]) begin
            send_cmd(tbl[t].chan, tbl[t].mode, tbl[t].width, n);
            mon_chan = CW'(tbl[t].chan);
            wait_ticks(40);
            chk("tbl_width", 32'(mon_width_us), 32'(tbl[t].exp_w));
            chk("tbl_at_target", 32'(at_target[tbl[t].chan]), 32'd1);
        end

        // Ramp ch2 200 -> 150: last step clamps onto the target.
        mon_chan = 3'd2;
        send_cmd(2, 1'b0, 150, n);
        wait_ticks(1);
        chk("ramp_first", 32'(mon_width_us), 32'd197);
        chk("ramp_at_target", 32'(at_target[2]), 32'd0);
        wait_ticks(15);
        chk("ramp_16", 32'(mon_width_us), 32'd152);
        wait_ticks(1);
        chk("ramp_done", 32'(mon_width_us), 32'd150);
        chk("ramp_done_at", 32'(at_target[2]), 32'd1);

        // Sweep ch4 from 150: up, hold+flip at MAX, down, hold+flip at MIN.
        mon_chan = 3'd4;
        send_cmd(4, 1'b1, 0, n);
        wait_ticks(17);
        chk("sweep_max", 32'(mon_width_us), 32'd200);
        chk("sweep_at_target", 32'(at_target[4]), 32'd0);
        wait_ticks(1);
        chk("sweep_hold_max", 32'(mon_width_us), 32'd200);
        wait_ticks(1);
        chk("sweep_down", 32'(mon_width_us), 32'd197);
        wait_ticks(33);
        chk("sweep_min", 32'(mon_width_us), 32'd100);
        wait_ticks(1);
        chk("sweep_hold_min", 32'(mon_width_us), 32'd100);
        wait_ticks(1);
        chk("sweep_up", 32'(mon_width_us), 32'd103);

        // Reset in the middle of a pulse while sweeping.
        n = 0;
        while (k % F != 60 && n < F) begin cycle(); n++; end
        chk("pre_rst_pwm4", 32'(pwm_out[4]), 32'd1);
        do_reset();
        for (int i = 0; i < NCH; i++) begin
            mon_chan = CW'(i);
            cycle();
            cycle();
            chk("post_rst_width", 32'(mon_width_us), 32'(MID));
            chk("post_rst_at", 32'(at_target[i]), 32'd1);
        end

        // Command to a non-existent channel.
        send_cmd(7, 1'b0, 180, n);
        errs = int'(cmd_err);
        repeat (3) begin cycle(); errs += int'(cmd_err); end
        chk("bad_chan_err_pulses", 32'(errs), 32'd1);

        // Command presented on the tick cycle waits one cycle.
        n = 0;
        while (k % UDIV != UDIV - 1 && n < UDIV) begin cycle(); n++; end
        chk("tick_ready_low", 32'(cmd_ready), 32'd0);
        send_cmd(1, 1'b0, 180, n);
        chk("tick_accept_cycles", 32'(n), 32'd2);

        // Random traffic against the model.
        for (int j = 0; j < 20000; j++) begin
            cmd_valid    = ($urandom % 4) == 0;
            cmd_chan     = CW'($urandom % 8);
            cmd_mode     = ($urandom % 4) == 0;
            cmd_width_us = 16'($urandom_range(0, 400));
            mon_chan     = CW'($urandom % 8);
            cycle();
        end
        cmd_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/servo_pwm_bank.md
# servo_pwm_bank

Multi-channel hobby-servo PWM generator with per-channel slew-limited motion and an autonomous sweep mode. It generalises the single fixed-sweep servo driver to NUM_CH independently commanded channels sharing one frame timebase. Commands arrive over a valid/ready port, and each channel's pulse width changes only at frame boundaries. It sits between the arm control logic and the servo output pins, and exposes a width monitor for the seven-segment display path.

## Interface
- NUM_CH, 5, number of servo channels (1..16)
- CLK_HZ, 50_000_000, input clock frequency; must be a multiple of 1_000_000
- FRAME_US, 20000, PWM frame period in µs (50 Hz)
- MIN_US, 1000, minimum legal pulse width in µs
- MAX_US, 2000, maximum legal pulse width in µs
- STEP_US, 10, maximum width change per update tick in µs
- UPDATE_DIV, 250000, clock cycles per update tick (200 Hz at 50 MHz)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command can be accepted this cycle
- cmd_chan  in  CW=max(1,$clog2(NUM_CH))  target channel
- cmd_mode  in  1  0 = track target, 1 = sweep MIN_US..MAX_US
- cmd_width_us  in  16  target width in µs; ignored in sweep mode
- cmd_err  out  1  one-cycle pulse when an accepted command has cmd_chan >= NUM_CH
- mon_chan  in  CW  channel selected for monitoring
- mon_width_us  out  16  current (ramped) width of mon_chan; 0 if mon_chan >= NUM_CH
- frame_start  out  1  one-cycle pulse at the start of each frame
- at_target  out  NUM_CH  per channel: current width == target, track mode only
- pwm_out  out  NUM_CH  servo pulse outputs

## Operation
- Each channel holds these registers:
  - target (16b), clamped to [MIN_US, MAX_US] when written
  - cur (16b): the ramped width
  - active (16b): width used for the current frame
  - mode (1b)
  - dir (1b, 1 = up)
- Command handshake:
  - Accept occurs when cmd_valid && cmd_ready.
  - cmd_ready = 0 only on the update-tick cycle; it is 1 at all other times, including the first cycle after rst deasserts.
  - An accepted command to a valid channel writes mode. In track mode it also writes the clamped target.
  - dir and cur are not modified by a command.
  - An accepted command to an invalid channel changes no state and pulses cmd_err on the next cycle.
- Update tick: a one-cycle strobe every UPDATE_DIV cycles. Every channel updates in parallel.
  - Track mode: if cur < target, cur = min(cur+STEP_US, target). If cur > target, cur = max(cur−STEP_US, target).
  - Sweep, dir=1: if cur >= MAX_US, set dir=0 and leave cur unchanged. Otherwise cur = min(cur+STEP_US, MAX_US).
  - Sweep, dir=0: if cur <= MIN_US, set dir=1 and leave cur unchanged. Otherwise cur = max(cur−STEP_US, MIN_US).
- Frame timing:
  - A µs prescaler counts 0..CLK_HZ/1e6−1.
  - frame_us counts 0..FRAME_US−1, advancing when the prescaler wraps.
  - At a frame start, active <= cur for all channels. Widths never change mid-pulse.
- pwm_out[i] is registered and high while frame_us < active[i].
- All arithmetic is 17-bit internally, with no wrap-around.
- Reset values:
  - cur = target = active = (MIN_US+MAX_US)/2; mode = track; dir = 1
  - all counters 0; pwm_out = 0; frame_start = 0; cmd_err = 0; at_target = all 1s
- Reset asserted mid-frame or mid-ramp forces the reset values immediately, with no completion of the current pulse.

## Timing
- Frame period: FRAME_US·CLK_HZ/1e6 cycles (1,000,000 at defaults).
- High time: active·CLK_HZ/1e6 cycles, exact (75,000 cycles for 1500 µs at defaults).
- pwm_out rises 1 cycle after frame_start, because both are registered from the same counter state.
- frame_start is asserted in the cycle where frame_us == 0 and prescaler == 0.
- Command-to-target latency is 1 cycle. The first width change appears on the next update tick. The first pwm change appears at the next frame start after that.
- If an update tick and a frame start coincide, active captures cur as it was before that tick.
- at_target and mon_width_us are registered, with 1-cycle latency from cur.

## Test plan
- Reset release: all pwm_out high for exactly 75,000 cycles of each 1,000,000-cycle frame; at_target = 5'b11111; cmd_ready = 1.
- Track command to ch2 with 2000 µs: ch2 ramps +10 µs per tick and reaches 2000 after 50 ticks. at_target[2] is 0 during the ramp and 1 after. The high time of ch0, ch1, ch3 and ch4 remains 75,000 cycles.
- cmd_width_us = 500 and then 3000 on ch0: targets clamp to 1000 and 2000. The pulse never goes below 50,000 or above 100,000 cycles.
- Sweep on ch4 starting from 1500: reaches 2000 after 50 ticks. The next tick holds 2000 and flips dir. It reaches 1000 after 100 more ticks. The period is 202 ticks.
- cmd_chan = 7 with NUM_CH = 5: command is accepted, cmd_err pulses once, and no channel state changes. A command presented on the update-tick cycle sees cmd_ready = 0 and is accepted on the next cycle.
- Assert rst mid-pulse during a sweep: pwm_out goes to 0 asynchronously. After release, all channels are at 1500 µs in track mode.
